// File: rtl/sram_prot_pkg.sv
// sram_prot_pkg: shared types and helpers for the protected single-port SRAM.
//   state_e   - controller states (INIT zeroises the array, RUN serves requests)
//   odd_par   - odd-parity bit for one byte (byte + parity has an odd number of 1s)
//   lat_ok    - legal READ_LAT values
package sram_prot_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic bit lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: first-word-fall-through FIFO; rdata shows the head entry
// whenever empty=0.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset (drops all entries)
//   push, wdata        write one entry (ignored when full)
//   pop                remove head entry (ignored when empty)
//   rdata              head entry
//   full, empty, count occupancy status
module sram_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sp_sram_prot.sv
// sp_sram_prot: single-port SRAM wrapper with per-byte odd parity, configurable
// read latency, in-order response FIFO with backpressure and zeroisation after
// reset.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   req_i/gnt_o/gntpar_o  request handshake (gntpar_o = ~gnt_o)
//   we_i, addr_i, wdata_i, be_i, err_inj_i  request payload
//   rdata_o, rerr_o       response payload (zero when no response is valid)
//   rvalid_o/rvalidpar_o/rready_i  response handshake (rvalidpar_o = ~rvalid_o)
//   init_done_o           array zeroisation finished
module sp_sram_prot
  import sram_prot_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_WORDS  = 1024,
  parameter int  READ_LAT   = 1,
  parameter int  RSP_DEPTH  = 2,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  output logic                    gntpar_o,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic                    err_inj_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rerr_o,
  output logic                    rvalid_o,
  output logic                    rvalidpar_o,
  input  logic                    rready_i,
  output logic                    init_done_o
);
  localparam int NB     = DATA_WIDTH / 8;
  localparam int STAGES = READ_LAT - 1;
  localparam int CW     = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } rsp_t;

  if (!lat_ok(READ_LAT) || (DATA_WIDTH % 8 != 0) || (RSP_DEPTH < 1)) begin : g_bad_cfg
    $error("sp_sram_prot: illegal parameter combination");
  end

  // ---------------- controller ----------------
  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;
  logic                  run;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      INIT: begin
        if (init_cnt == ADDR_WIDTH'(NUM_WORDS - 1)) state_nxt = RUN;
        else                                        init_cnt_nxt = init_cnt + 1'b1;
      end
      RUN:     ;
      default: state_nxt = INIT;
    endcase
  end

  assign run         = (state == RUN);
  assign init_done_o = run;

  // ---------------- grant / outstanding count ----------------
  // cnt covers responses in the read pipeline as well as in the FIFO, so
  // granting only while cnt < RSP_DEPTH keeps the FIFO from overflowing.
  logic [CW-1:0] cnt;
  logic          acc, pop;

  assign gnt_o    = run & (cnt < CW'(RSP_DEPTH));
  assign gntpar_o = ~gnt_o;
  assign acc      = req_i & gnt_o;
  assign pop      = rvalid_o & rready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt <= '0;
    else begin
      case ({acc, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- storage ----------------
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [NB-1:0]         par [NUM_WORDS];
  logic                  in_range;

  assign in_range = {1'b0, addr_i} < (ADDR_WIDTH + 1)'(NUM_WORDS);

  // No reset here so the array maps onto RAM; INIT zeroes it word by word.
  always_ff @(posedge clk_i) begin
    if (!run) begin
      mem[init_cnt] <= '0;
      par[init_cnt] <= '1;
    end else if (acc && we_i && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          par[addr_i][b]        <= odd_par(wdata_i[8*b +: 8]) ^ err_inj_i;
        end
      end
    end
  end

  // Read is sampled at the accepting edge; stage 0 is the combinational word.
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NB-1:0]         rd_par;
  logic                  par_err;
  rsp_t                  rsp_d;

  assign rd_word = mem[addr_i];
  assign rd_par  = par[addr_i];

  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < NB; b++) par_err |= ~^{rd_par[b], rd_word[8*b +: 8]};
  end

  always_comb begin
    rsp_d = '0;
    if (!we_i) begin
      if (in_range) begin
        rsp_d.data = rd_word;
        rsp_d.err  = par_err;
      end else begin
        rsp_d.err  = 1'b1;
      end
    end
  end

  // ---------------- latency pipeline ----------------
  logic push;
  rsp_t push_rsp;

  if (STAGES == 0) begin : g_lat1
    assign push     = acc;
    assign push_rsp = rsp_d;
  end else begin : g_latn
    logic [STAGES-1:0] vld_pipe;
    rsp_t              rsp_pipe [STAGES];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_pipe <= '0;
        for (int s = 0; s < STAGES; s++) rsp_pipe[s] <= '0;
      end else begin
        vld_pipe[0] <= acc;
        rsp_pipe[0] <= rsp_d;
        for (int s = 1; s < STAGES; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          rsp_pipe[s] <= rsp_pipe[s-1];
        end
      end
    end
    assign push     = vld_pipe[STAGES-1];
    assign push_rsp = rsp_pipe[STAGES-1];
  end

  // ---------------- response FIFO ----------------
  rsp_t                            head;
  logic                            empty, unused_full;
  logic [$clog2(RSP_DEPTH+1)-1:0]  unused_count;

  sram_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (push_rsp),
    .pop    (pop),
    .rdata  (head),
    .full   (unused_full),
    .empty  (empty),
    .count  (unused_count)
  );

  assign rvalid_o    = ~empty;
  assign rvalidpar_o = empty;
  assign rdata_o     = rvalid_o ? head.data : '0;
  assign rerr_o      = rvalid_o & head.err;

endmodule

// File: tb/tb_sp_sram_prot.sv
// tb_sp_sram_prot: two configurations driven with identical stimulus
//   dut0: NUM_WORDS=16, READ_LAT=1, RSP_DEPTH=2
//   dut1: NUM_WORDS=12, READ_LAT=2, RSP_DEPTH=3
// Each is compared every cycle against a transaction-level model: a word
// array, a per-byte "corrupted" flag, and a queue of expected responses
// stamped with the cycle at which they become visible.
module tb_sp_sram_prot;
  logic        clk    = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req = 1'b0, we = 1'b0, err_inj = 1'b0, rready = 1'b0;
  logic [3:0]  addr = '0, be = '0;
  logic [31:0] wdata = '0;

  logic [1:0]  gnt, gntpar, rvalid, rvalidpar, rerr, init_done;
  logic [31:0] rdata [2];

  always #5 clk = ~clk;

  sp_sram_prot #(.DATA_WIDTH(32), .NUM_WORDS(16), .READ_LAT(1), .RSP_DEPTH(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt[0]), .gntpar_o(gntpar[0]),
    .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be), .err_inj_i(err_inj),
    .rdata_o(rdata[0]), .rerr_o(rerr[0]), .rvalid_o(rvalid[0]), .rvalidpar_o(rvalidpar[0]),
    .rready_i(rready), .init_done_o(init_done[0]));

  sp_sram_prot #(.DATA_WIDTH(32), .NUM_WORDS(12), .READ_LAT(2), .RSP_DEPTH(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt[1]), .gntpar_o(gntpar[1]),
    .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be), .err_inj_i(err_inj),
    .rdata_o(rdata[1]), .rerr_o(rerr[1]), .rvalid_o(rvalid[1]), .rvalidpar_o(rvalidpar[1]),
    .rready_i(rready), .init_done_o(init_done[1]));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  int NW  [2] = '{16, 12};
  int LAT [2] = '{1, 2};
  int DEP [2] = '{2, 3};

  exp_t        q    [2][$];
  logic [31:0] mm   [2][16];
  logic [3:0]  bad  [2][16];
  bit          run  [2];
  int          icnt [2];
  int          cyc, tests, fails;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d cyc%0d: got %0h expected %0h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      run[i]  = 1'b0;
      icnt[i] = 0;
      for (int w = 0; w < 16; w++) begin
        mm[i][w]  = '0;
        bad[i][w] = '0;
      end
    end
  endtask

  // Assert reset just after a negedge and check outputs clear immediately.
  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rvalid",    i, 32'(rvalid[i]),    32'd0);
      chk("rst_rvalidpar", i, 32'(rvalidpar[i]), 32'd1);
      chk("rst_gnt",       i, 32'(gnt[i]),       32'd0);
      chk("rst_gntpar",    i, 32'(gntpar[i]),    32'd1);
      chk("rst_init_done", i, 32'(init_done[i]), 32'd0);
      chk("rst_rdata",     i, rdata[i],          32'd0);
      chk("rst_rerr",      i, 32'(rerr[i]),      32'd0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model past the edge.
  task automatic step(input logic rq, input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic inj, input logic rr);
    bit   ev, eg;
    exp_t e;
    req = rq; we = w; addr = a; wdata = d; be = b; err_inj = inj; rready = rr;
    #1;
    for (int i = 0; i < 2; i++) begin
      ev = (q[i].size() > 0) && (q[i][0].due <= cyc);
      eg = run[i] && (q[i].size() < DEP[i]);
      chk("gnt",       i, 32'(gnt[i]),       32'(eg));
      chk("gntpar",    i, 32'(gntpar[i]),    32'(!eg));
      chk("rvalid",    i, 32'(rvalid[i]),    32'(ev));
      chk("rvalidpar", i, 32'(rvalidpar[i]), 32'(!ev));
      chk("rdata",     i, rdata[i],          ev ? q[i][0].data : 32'd0);
      chk("rerr",      i, 32'(rerr[i]),      ev ? 32'(q[i][0].err) : 32'd0);
      chk("init_done", i, 32'(init_done[i]), 32'(run[i]));
      if (ev && rr) void'(q[i].pop_front());
      if (rq && eg) begin
        if (w) begin
          if (a < NW[i]) begin
            for (int k = 0; k < 4; k++) begin
              if (b[k]) begin
                mm[i][a][8*k +: 8] = d[8*k +: 8];
                bad[i][a][k]       = inj;
              end
            end
          end
          e = '{32'd0, 1'b0, cyc + LAT[i]};
        end else if (a < NW[i]) begin
          e = '{mm[i][a], |bad[i][a], cyc + LAT[i]};
        end else begin
          e = '{32'd0, 1'b1, cyc + LAT[i]};
        end
        q[i].push_back(e);
      end
      if (!run[i]) begin
        icnt[i]++;
        if (icnt[i] == NW[i]) run[i] = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    repeat (n) step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, rr);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    model_reset();
    #2;
    do_reset();

    // Zeroisation: read of addr 5 requested throughout INIT.
    repeat (18) step(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Full write, partial byte write, read back.
    step(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd3, 32'h00000011, 4'h1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd3, 32'd0, 4'h0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Backpressure: four reads offered with rready low, then release.
    step(1'b1, 1'b0, 4'd3, 32'd0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd5, 32'd0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd3, 32'd0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd5, 32'd0, 4'h0, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(5, 1'b1);

    // Back-to-back reads with rready high.
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0, 4'(n), 32'd0, 4'h0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Parity error injection on one byte, then a clean rewrite.
    step(1'b1, 1'b1, 4'd7, 32'h0000AB00, 4'h2, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'd7, 32'd0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd7, 32'h12345678, 4'hF, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd7, 32'd0, 4'h0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Address 13 (out of range for dut1), write with no byte enables.
    step(1'b1, 1'b1, 4'd13, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd13, 32'd0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd3, 32'd0, 4'h0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Random traffic.
    for (int n = 0; n < 500; n++)
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) != 0));
    idle(6, 1'b1);

    // Reset with responses pending; zeroisation must restart.
    step(1'b1, 1'b1, 4'd2, 32'h55AA55AA, 4'hF, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd2, 32'd0, 4'h0, 1'b0, 1'b0);
    idle(2, 1'b0);
    do_reset();
    repeat (18) step(1'b1, 1'b0, 4'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
